// File: rtl/piso_serializer.sv
// Parallel-in/serial-out feeder: takes N-bit words over valid/ready and emits one bit per shift_en clock.
// Define PISO_PARITY_EN to append an even-parity bit after each word's N data bits.
module piso_serializer #(
    parameter int unsigned N         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic         shift_en,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         frame_start,
    output logic         busy
);

`ifdef PISO_PARITY_EN
    localparam int unsigned F = N + 1;
`else
    localparam int unsigned F = N;
`endif
    localparam int unsigned CW = $clog2(F);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
`ifdef PISO_PARITY_EN
    localparam logic [1:0] ST_PARITY = 2'd2;
`endif

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ser_out_q, ser_out_d;
    logic          ser_valid_q, ser_valid_d;
    logic          frame_start_q, frame_start_d;
`ifdef PISO_PARITY_EN
    logic          parity_q, parity_d;
`endif

    logic last_bit_c;
    logic accept_c;
    logic load_c;

    // Bit that leaves the word first, and the word with that bit removed (zero-filled).
    function automatic logic head_bit(input logic [N-1:0] w);
        return MSB_FIRST ? w[N-1] : w[0];
    endfunction

    function automatic logic [N-1:0] advance(input logic [N-1:0] w);
        return MSB_FIRST ? {w[N-2:0], 1'b0} : {1'b0, w[N-1:1]};
    endfunction

    always_comb begin
`ifdef PISO_PARITY_EN
        last_bit_c = (state_q == ST_PARITY);
`else
        last_bit_c = (state_q == ST_SHIFT) && (cnt_q == CW'(F - 1));
`endif
    end

    assign in_ready = (state_q == ST_IDLE) | (last_bit_c & shift_en);
    assign accept_c = in_valid & in_ready;

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        cnt_d         = cnt_q;
        ser_out_d     = ser_out_q;
        ser_valid_d   = ser_valid_q;
        frame_start_d = frame_start_q;
`ifdef PISO_PARITY_EN
        parity_d      = parity_q;
`endif
        load_c        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load_c = accept_c;
            end
            ST_SHIFT: begin
                if (shift_en) begin
                    if (last_bit_c) begin
                        load_c        = accept_c;
                        state_d       = ST_IDLE;
                        shreg_d       = '0;
                        cnt_d         = '0;
                        ser_out_d     = 1'b0;
                        ser_valid_d   = 1'b0;
                        frame_start_d = 1'b0;
                    end else begin
                        cnt_d         = cnt_q + CW'(1);
                        frame_start_d = 1'b0;
                        ser_out_d     = head_bit(shreg_q);
                        shreg_d       = advance(shreg_q);
`ifdef PISO_PARITY_EN
                        if (cnt_q == CW'(N - 1)) begin
                            state_d   = ST_PARITY;
                            ser_out_d = parity_q;
                        end
`endif
                    end
                end
            end
`ifdef PISO_PARITY_EN
            ST_PARITY: begin
                if (shift_en) begin
                    load_c        = accept_c;
                    state_d       = ST_IDLE;
                    shreg_d       = '0;
                    cnt_d         = '0;
                    ser_out_d     = 1'b0;
                    ser_valid_d   = 1'b0;
                    frame_start_d = 1'b0;
                end
            end
`endif
            default: begin
                state_d       = ST_IDLE;
                shreg_d       = '0;
                cnt_d         = '0;
                ser_out_d     = 1'b0;
                ser_valid_d   = 1'b0;
                frame_start_d = 1'b0;
            end
        endcase

        // A captured word presents its first bit on the very next cycle.
        if (load_c) begin
            state_d       = ST_SHIFT;
            ser_out_d     = head_bit(in_data);
            shreg_d       = advance(in_data);
            cnt_d         = '0;
            ser_valid_d   = 1'b1;
            frame_start_d = 1'b1;
`ifdef PISO_PARITY_EN
            parity_d      = ^in_data;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            cnt_q         <= '0;
            ser_out_q     <= 1'b0;
            ser_valid_q   <= 1'b0;
            frame_start_q <= 1'b0;
`ifdef PISO_PARITY_EN
            parity_q      <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            cnt_q         <= cnt_d;
            ser_out_q     <= ser_out_d;
            ser_valid_q   <= ser_valid_d;
            frame_start_q <= frame_start_d;
`ifdef PISO_PARITY_EN
            parity_q      <= parity_d;
`endif
        end
    end

    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign frame_start = frame_start_q;
    assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: directed frame/stall/reset cases plus a randomized stream
// compared against a bit-list model built from the accepted words.
module tb_piso_serializer;

    localparam int unsigned N = 8;
`ifdef PISO_PARITY_EN
    localparam int unsigned F = N + 1;
`else
    localparam int unsigned F = N;
`endif
    localparam int NW = 40;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [N-1:0] in_data;
    logic         in_valid, in_ready, shift_en;
    logic         ser_out, ser_valid, frame_start, busy;

    logic [N-1:0] l_in_data;
    logic         l_in_valid, l_in_ready, l_shift_en;
    logic         l_ser_out, l_ser_valid, l_frame_start, l_busy;

    int n_pass  = 0;
    int n_total = 0;

    logic mon_en = 1'b0;
    logic got_bits[$];
    logic got_fs[$];
    logic exp_bits[$];

    piso_serializer #(.N(N), .MSB_FIRST(1'b1)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .shift_en(shift_en), .ser_out(ser_out),
        .ser_valid(ser_valid), .frame_start(frame_start), .busy(busy)
    );

    piso_serializer #(.N(N), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .reset_n(reset_n), .in_data(l_in_data), .in_valid(l_in_valid),
        .in_ready(l_in_ready), .shift_en(l_shift_en), .ser_out(l_ser_out),
        .ser_valid(l_ser_valid), .frame_start(l_frame_start), .busy(l_busy)
    );

    always #5 clk = ~clk;

    // Record every bit actually transferred downstream (valid & shift_en at the coming edge).
    always @(negedge clk) begin
        if (mon_en && ser_valid && shift_en) begin
            got_bits.push_back(ser_out);
            got_fs.push_back(frame_start);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Frame bit i of word w: data bits in the chosen order, then parity at i == N.
    function automatic logic fbit(input logic [N-1:0] w, input int i, input bit msb);
        if (i >= int'(N)) return ^w;
        return msb ? w[N-1-i] : w[i];
    endfunction

    task automatic single_frame(input logic [N-1:0] w, input string nm);
        in_data  = w;
        in_valid = 1'b1;
        shift_en = 1'b1;
        chk({nm, "_ready_idle"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = N'($urandom);
        for (int k = 1; k <= int'(F); k++) begin
            chk($sformatf("%s_valid_c%0d", nm, k), 32'(ser_valid), 32'd1);
            chk($sformatf("%s_bit_c%0d", nm, k), 32'(ser_out), 32'(fbit(w, k - 1, 1'b1)));
            chk($sformatf("%s_fs_c%0d", nm, k), 32'(frame_start), 32'(k == 1));
            chk($sformatf("%s_rdy_c%0d", nm, k), 32'(in_ready), 32'(k == int'(F)));
            tick();
        end
        chk({nm, "_end_valid"}, 32'(ser_valid), 32'd0);
        chk({nm, "_end_out"}, 32'(ser_out), 32'd0);
        chk({nm, "_end_busy"}, 32'(busy), 32'd0);
        chk({nm, "_end_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [N-1:0] w, w1, w2;
        logic         acc;
        int           bi;
        logic [F-1:0] gv, ev;
        int           fs_cnt;

        reset_n    = 1'b1;
        in_data    = '0;
        in_valid   = 1'b0;
        shift_en   = 1'b1;
        l_in_data  = '0;
        l_in_valid = 1'b0;
        l_shift_en = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ser_out", 32'(ser_out), 32'd0);
        chk("rst_ser_valid", 32'(ser_valid), 32'd0);
        chk("rst_frame_start", 32'(frame_start), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Single words, including parity-sensitive patterns.
        single_frame(8'hA5, "a5");
        single_frame(8'h07, "w07");
        single_frame(8'h03, "w03");

        // Back-to-back words with in_valid held.
        w1 = 8'hA5;
        w2 = 8'h3C;
        in_data  = w1;
        in_valid = 1'b1;
        shift_en = 1'b1;
        tick();
        in_data = w2;
        for (int k = 1; k <= 2 * int'(F); k++) begin
            w  = (k <= int'(F)) ? w1 : w2;
            bi = (k <= int'(F)) ? k - 1 : k - 1 - int'(F);
            chk($sformatf("b2b_valid_c%0d", k), 32'(ser_valid), 32'd1);
            chk($sformatf("b2b_bit_c%0d", k), 32'(ser_out), 32'(fbit(w, bi, 1'b1)));
            chk($sformatf("b2b_fs_c%0d", k), 32'(frame_start), 32'(k == 1 || k == int'(F) + 1));
            if (k == int'(F) + 1) in_valid = 1'b0;
            tick();
        end
        chk("b2b_idle", 32'(busy), 32'd0);

        // Stall three cycles while the third bit is presented.
        w = 8'hA5;
        in_data  = w;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= int'(F) + 4; k++) begin
            bi = (k <= 3) ? k - 1 : ((k <= 6) ? 2 : k - 4);
            chk($sformatf("stall_valid_c%0d", k), 32'(ser_valid), 32'(k <= int'(F) + 3));
            if (k <= int'(F) + 3)
                chk($sformatf("stall_bit_c%0d", k), 32'(ser_out), 32'(fbit(w, bi, 1'b1)));
            shift_en = (k >= 3 && k <= 5) ? 1'b0 : 1'b1;
            tick();
        end

        // Reset mid-frame, then a full word of ones.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        shift_en = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        chk("rstmid_pre_bit", 32'(ser_out), 32'(fbit(8'hA5, 5, 1'b1)));
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid_ser_out", 32'(ser_out), 32'd0);
        chk("rstmid_ser_valid", 32'(ser_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        #1 reset_n = 1'b1;
        #1;
        chk("rstmid_ready", 32'(in_ready), 32'd1);
        tick();
        single_frame(8'hFF, "ff");

        // LSB-first instance.
        w = 8'h01;
        l_in_data  = w;
        l_in_valid = 1'b1;
        tick();
        l_in_valid = 1'b0;
        for (int k = 1; k <= int'(F); k++) begin
            chk($sformatf("lsb_valid_c%0d", k), 32'(l_ser_valid), 32'd1);
            chk($sformatf("lsb_bit_c%0d", k), 32'(l_ser_out), 32'(fbit(w, k - 1, 1'b0)));
            tick();
        end
        chk("lsb_end_valid", 32'(l_ser_valid), 32'd0);

        // Randomized stream with random stalls and gaps.
        mon_en = 1'b1;
        for (int n = 0; n < NW; n++) begin
            w = N'($urandom);
            for (int i = 0; i < int'(F); i++) exp_bits.push_back(fbit(w, i, 1'b1));
            in_data  = w;
            in_valid = 1'b1;
            acc      = 1'b0;
            for (int c = 0; c < 64 && !acc; c++) begin
                shift_en = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                acc = in_ready;
                tick();
            end
            chk($sformatf("rnd_accept_w%0d", n), 32'(acc), 32'd1);
            in_valid = 1'b0;
            in_data  = N'($urandom);
            for (int g = $urandom_range(0, 2); g > 0; g--) begin
                shift_en = ($urandom_range(0, 3) != 0);
                tick();
            end
        end
        shift_en = 1'b1;
        for (int c = 0; c < 200 && busy; c++) tick();
        tick();
        mon_en = 1'b0;
        chk("rnd_drained", 32'(busy), 32'd0);
        chk("rnd_nbits", 32'(got_bits.size()), 32'(exp_bits.size()));
        for (int f = 0; f < NW; f++) begin
            gv = '0;
            ev = '0;
            fs_cnt = 0;
            for (int i = 0; i < int'(F); i++) begin
                bi = f * int'(F) + i;
                ev[F-1-i] = exp_bits[bi];
                if (bi < got_bits.size()) begin
                    gv[F-1-i] = got_bits[bi];
                    if (got_fs[bi]) fs_cnt = fs_cnt + ((i == 0) ? 1 : 100);
                end
            end
            chk($sformatf("rnd_frame%0d", f), 32'(gv), 32'(ev));
            chk($sformatf("rnd_fs%0d", f), 32'(fs_cnt), 32'd1);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
